mem_store: RTL



---
 rtl/mem_store.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_store.sv
// RV32I store unit for a two-port byte-wide memory: SB/SH are written in one
// beat, SW is split into two beats while the pipeline is held on stall.
module mem_store #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        funct3,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [31:0]       write_data,
    input  logic              mem_ready,
    output logic              stall,
    output logic              p1_write_en,
    output logic              p2_write_en,
    output logic [ADDR_W-1:0] p1_addr,
    output logic [ADDR_W-1:0] p2_addr,
    output logic [7:0]        p1_data,
    output logic [7:0]        p2_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    // Handshake: a beat is written in every cycle the matching port enable is
    // high and mem_ready is high; until then the port outputs stay frozen.
    // Upstream holds its request while stall is high; write_en is only looked
    // at in IDLE.

    state_t            state_q, state_d;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       hi_bytes_q;    // {D[31:24], D[15:8]} kept for beat 1
    logic              p1_we_q, p2_we_q;
    logic [ADDR_W-1:0] p1_addr_q, p2_addr_q;
    logic [7:0]        p1_data_q, p2_data_q;
    logic              done_q, err_q;

    logic legal_f3;
    logic accept;
    logic reject;
    logic advance;
    logic last_fire;

    assign legal_f3 = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        advance   = 1'b0;
        last_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_en) begin
                    if (legal_f3) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = BEAT0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            BEAT0: begin
                stall = 1'b1;
                if (mem_ready) begin
                    if (f3_q == F3_SW) begin
                        advance = 1'b1;
                        state_d = BEAT1;
                    end else begin
                        // Final beat of a byte/halfword store releases the pipe now.
                        last_fire = 1'b1;
                        stall     = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            BEAT1: begin
                stall = 1'b1;
                if (mem_ready) begin
                    last_fire = 1'b1;
                    stall     = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q       <= '0;
            addr_q     <= '0;
            hi_bytes_q <= '0;
            p1_we_q    <= 1'b0;
            p2_we_q    <= 1'b0;
            p1_addr_q  <= '0;
            p2_addr_q  <= '0;
            p1_data_q  <= '0;
            p2_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= last_fire;
            err_q  <= reject;
            if (accept) begin
                f3_q       <= funct3;
                addr_q     <= write_addr;
                hi_bytes_q <= {write_data[31:24], write_data[15:8]};
                p1_we_q    <= 1'b1;
                p2_we_q    <= (funct3 != F3_SB);
                p1_addr_q  <= write_addr;
                p1_data_q  <= write_data[7:0];
                if (funct3 == F3_SH) begin
                    p2_addr_q <= write_addr + ADDR_W'(1);
                    p2_data_q <= write_data[15:8];
                end else if (funct3 == F3_SW) begin
                    p2_addr_q <= write_addr + ADDR_W'(2);
                    p2_data_q <= write_data[23:16];
                end
            end else if (advance) begin
                // Second word beat: the odd bytes, addresses wrap naturally.
                p1_addr_q <= addr_q + ADDR_W'(1);
                p1_data_q <= hi_bytes_q[7:0];
                p2_addr_q <= addr_q + ADDR_W'(3);
                p2_data_q <= hi_bytes_q[15:8];
            end else if (last_fire) begin
                p1_we_q <= 1'b0;
                p2_we_q <= 1'b0;
            end
        end
    end

    assign p1_write_en = p1_we_q;
    assign p2_write_en = p2_we_q;
    assign p1_addr     = p1_addr_q;
    assign p2_addr     = p2_addr_q;
    assign p1_data     = p1_data_q;
    assign p2_data     = p2_data_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule
